// File: rtl/mbc1_mapper.sv
// MBC1-style cartridge bank controller: decodes CPU control writes, maps CPU
// addresses onto banked ROM / external RAM and returns read data one cycle later.
module mbc1_mapper #(
  parameter int unsigned ROM_ADDR_W = 15,
  parameter int unsigned RAM_ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_rvalid,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic [7:0]            ram_rdata,
  output logic                  ram_enabled
);

  localparam int unsigned ROM_FULL_W = 21;
  localparam int unsigned RAM_FULL_W = 15;

  typedef enum logic [1:0] {
    RG_NONE = 2'd0,
    RG_ROM  = 2'd1,
    RG_RAM  = 2'd2
  } region_e;

  logic                  ram_en_q, ram_en_d;
  logic [4:0]            bank1_q, bank1_d;
  logic [1:0]            bank2_q, bank2_d;
  logic                  mode_q, mode_d;
  logic                  wr_q, wr_d;
  logic                  rvalid_q, rvalid_d;
  region_e               region_q, region_d;

  logic                  commit;
  logic                  rom_sel;
  logic                  ram_sel;
  logic [6:0]            rom_bank;
  logic [ROM_FULL_W-1:0] rom_full;
  logic [RAM_FULL_W-1:0] ram_full;

  assign commit  = cpu_wr & ~wr_q;
  assign rom_sel = ~cpu_addr[15];
  assign ram_sel = (cpu_addr[15:13] == 3'b101);

  // Lower ROM window only follows bank2 in mode 1; upper window always uses both.
  always_comb begin
    rom_bank = 7'd0;
    if (cpu_addr[14]) begin
      rom_bank = {bank2_q, bank1_q};
    end else if (mode_q) begin
      rom_bank = {bank2_q, 5'd0};
    end
  end

  assign rom_full = {rom_bank, cpu_addr[13:0]};
  assign ram_full = {(mode_q ? bank2_q : 2'b00), cpu_addr[12:0]};
  assign rom_addr = ROM_ADDR_W'(rom_full);
  assign ram_addr = RAM_ADDR_W'(ram_full);

  assign ram_wdata   = cpu_wdata;
  assign ram_we      = commit & ram_sel & ram_en_q & ~rst;
  assign ram_enabled = ram_en_q;
  assign cpu_rvalid  = rvalid_q;

  // Register updates and read-region capture.
  always_comb begin
    ram_en_d = ram_en_q;
    bank1_d  = bank1_q;
    bank2_d  = bank2_q;
    mode_d   = mode_q;
    wr_d     = cpu_wr;
    rvalid_d = cpu_rd;
    region_d = RG_NONE;

    if (commit) begin
      case (cpu_addr[15:13])
        3'b000:  ram_en_d = (cpu_wdata[3:0] == 4'hA);
        3'b001:  bank1_d  = (cpu_wdata[4:0] == 5'd0) ? 5'd1 : cpu_wdata[4:0];
        3'b010:  bank2_d  = cpu_wdata[1:0];
        3'b011:  mode_d   = cpu_wdata[0];
        default: ;
      endcase
    end

    if (cpu_rd) begin
      if (rom_sel) begin
        region_d = RG_ROM;
      end else if (ram_sel && ram_en_q) begin
        region_d = RG_RAM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en_q <= 1'b0;
      bank1_q  <= 5'd1;
      bank2_q  <= 2'd0;
      mode_q   <= 1'b0;
      wr_q     <= 1'b0;
      rvalid_q <= 1'b0;
      region_q <= RG_NONE;
    end else begin
      ram_en_q <= ram_en_d;
      bank1_q  <= bank1_d;
      bank2_q  <= bank2_d;
      mode_q   <= mode_d;
      wr_q     <= wr_d;
      rvalid_q <= rvalid_d;
      region_q <= region_d;
    end
  end

  // Memories have one-cycle latency, so their outputs line up with rvalid.
  always_comb begin
    case (region_q)
      RG_ROM:  cpu_rdata = rom_data;
      RG_RAM:  cpu_rdata = ram_rdata;
      default: cpu_rdata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_mbc1_mapper.sv
// Bench for mbc1_mapper: three parameterisations share one CPU bus and are
// compared against an arithmetic model of the bank registers and memories.
module tb_mbc1_mapper;

  localparam int ROM_W [3] = '{15, 16, 21};
  localparam int RAM_W [3] = '{13, 13, 15};

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic        cpu_rd;

  logic [7:0]  cpu_rdata_a, cpu_rdata_b, cpu_rdata_c;
  logic        cpu_rvalid_a, cpu_rvalid_b, cpu_rvalid_c;
  logic [14:0] rom_addr_a;
  logic [15:0] rom_addr_b;
  logic [20:0] rom_addr_c;
  logic [7:0]  rom_data_a, rom_data_b, rom_data_c;
  logic [12:0] ram_addr_a, ram_addr_b;
  logic [14:0] ram_addr_c;
  logic [7:0]  ram_wdata_a, ram_wdata_b, ram_wdata_c;
  logic        ram_we_a, ram_we_b, ram_we_c;
  logic [7:0]  ram_rdata_a, ram_rdata_b, ram_rdata_c;
  logic        ram_enabled_a, ram_enabled_b, ram_enabled_c;

  logic [7:0]  mem_a [8192]  = '{default: 8'h00};
  logic [7:0]  mem_b [8192]  = '{default: 8'h00};
  logic [7:0]  mem_c [32768] = '{default: 8'h00};

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          m_ram_en, m_bank1, m_bank2, m_mode, m_wr_q;
  logic [7:0]  m_mem [3][32768];

  // per-step observations and expectations
  int          obs_rom [3], obs_ram [3], exp_rom [3], exp_ram [3];
  logic        obs_we [3], obs_en [3], obs_rv [3];
  logic [7:0]  obs_rd [3], exp_rd [3];
  logic        exp_we, exp_en, exp_rv;

  mbc1_mapper #(.ROM_ADDR_W(15), .RAM_ADDR_W(13)) u_a (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata_a), .cpu_rvalid(cpu_rvalid_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .ram_addr(ram_addr_a),
    .ram_wdata(ram_wdata_a), .ram_we(ram_we_a), .ram_rdata(ram_rdata_a),
    .ram_enabled(ram_enabled_a));

  mbc1_mapper #(.ROM_ADDR_W(16), .RAM_ADDR_W(13)) u_b (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata_b), .cpu_rvalid(cpu_rvalid_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .ram_addr(ram_addr_b),
    .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_rdata(ram_rdata_b),
    .ram_enabled(ram_enabled_b));

  mbc1_mapper #(.ROM_ADDR_W(21), .RAM_ADDR_W(15)) u_c (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata_c), .cpu_rvalid(cpu_rvalid_c),
    .rom_addr(rom_addr_c), .rom_data(rom_data_c), .ram_addr(ram_addr_c),
    .ram_wdata(ram_wdata_c), .ram_we(ram_we_c), .ram_rdata(ram_rdata_c),
    .ram_enabled(ram_enabled_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input int x);
    return 8'(x ^ (x >> 8) ^ (x >> 16) ^ 32'h5A);
  endfunction

  // synchronous ROMs and RAMs around each instance
  always @(posedge clk) begin
    rom_data_a <= rom_byte(int'(rom_addr_a));
    rom_data_b <= rom_byte(int'(rom_addr_b));
    rom_data_c <= rom_byte(int'(rom_addr_c));
    if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
    if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    if (ram_we_c) mem_c[ram_addr_c] <= ram_wdata_c;
    ram_rdata_a <= mem_a[ram_addr_a];
    ram_rdata_b <= mem_b[ram_addr_b];
    ram_rdata_c <= mem_c[ram_addr_c];
  end

  function automatic int model_rom(input int w, input logic [15:0] a);
    int bank;
    if (a < 16'h4000) bank = (m_mode != 0) ? m_bank2 * 32 : 0;
    else              bank = m_bank2 * 32 + m_bank1;
    return (bank * 16384 + int'(a) % 16384) % (1 << w);
  endfunction

  function automatic int model_ram(input int w, input logic [15:0] a);
    int hi;
    hi = (m_mode != 0) ? m_bank2 : 0;
    return (hi * 8192 + int'(a) % 8192) % (1 << w);
  endfunction

  function automatic bit in_ram(input logic [15:0] a);
    return (a >= 16'hA000) && (a < 16'hC000);
  endfunction

  task automatic model_reset();
    m_ram_en = 0; m_bank1 = 1; m_bank2 = 0; m_mode = 0; m_wr_q = 0;
  endtask

  // One bus cycle: drive, capture combinational outputs, advance model, capture read result.
  task automatic drive(input logic [15:0] a, input logic [7:0] d,
                       input logic wr, input logic rd, input logic r);
    bit commit;
    cpu_addr = a; cpu_wdata = d; cpu_wr = wr; cpu_rd = rd; rst = r;
    #1;
    obs_rom = '{int'(rom_addr_a), int'(rom_addr_b), int'(rom_addr_c)};
    obs_ram = '{int'(ram_addr_a), int'(ram_addr_b), int'(ram_addr_c)};
    obs_we  = '{ram_we_a, ram_we_b, ram_we_c};
    obs_en  = '{ram_enabled_a, ram_enabled_b, ram_enabled_c};
    commit  = wr && (m_wr_q == 0);
    exp_we  = commit && !r && in_ram(a) && (m_ram_en != 0);
    exp_en  = (m_ram_en != 0);
    exp_rv  = rd && !r;
    for (int i = 0; i < 3; i++) begin
      exp_rom[i] = model_rom(ROM_W[i], a);
      exp_ram[i] = model_ram(RAM_W[i], a);
      if (a < 16'h8000)                   exp_rd[i] = rom_byte(exp_rom[i]);
      else if (in_ram(a) && m_ram_en != 0) exp_rd[i] = m_mem[i][exp_ram[i]];
      else                                exp_rd[i] = 8'hFF;
    end
    if (r) begin
      model_reset();
    end else begin
      if (commit) begin
        if (a < 16'h2000)      m_ram_en = (d[3:0] == 4'hA) ? 1 : 0;
        else if (a < 16'h4000) m_bank1  = (int'(d) % 32 == 0) ? 1 : int'(d) % 32;
        else if (a < 16'h6000) m_bank2  = int'(d) % 4;
        else if (a < 16'h8000) m_mode   = int'(d) % 2;
      end
      if (exp_we) for (int i = 0; i < 3; i++) m_mem[i][exp_ram[i]] = d;
      m_wr_q = wr ? 1 : 0;
    end
    @(posedge clk);
    #1;
    obs_rv = '{cpu_rvalid_a, cpu_rvalid_b, cpu_rvalid_c};
    obs_rd = '{cpu_rdata_a, cpu_rdata_b, cpu_rdata_c};
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    drive(a, d, 1'b1, 1'b0, 1'b0);
    drive(a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
    drive(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rv[i] !== 1'b0 || obs_rd[i] !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_read inst%0d: rvalid=%0b rdata=%02h, want 0/FF", i, obs_rv[i], obs_rd[i]);
      end
      n_checks++;
      if (obs_en[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ram_en inst%0d: got %0b want 0", i, obs_en[i]);
      end
    end
  endtask

  task automatic test_basic_read();
    drive(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rom[i] !== 32'h4000) begin
        n_fail++;
        $display("FAIL basic_rom_addr inst%0d: got %h want 4000", i, obs_rom[i]);
      end
      n_checks++;
      if (obs_rv[i] !== 1'b1 || obs_rd[i] !== exp_rd[i]) begin
        n_fail++;
        $display("FAIL basic_rdata inst%0d: rvalid=%0b rdata=%02h want 1/%02h", i, obs_rv[i], obs_rd[i], exp_rd[i]);
      end
    end
    drive(16'h4000, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rv[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_single_pulse inst%0d: rvalid=%0b want 0", i, obs_rv[i]);
      end
    end
  endtask

  task automatic test_bank1();
    int want [3];
    wr_reg(16'h2000, 8'h00);
    drive(16'h4123, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rom[i] !== 32'h4123) begin
        n_fail++;
        $display("FAIL bank1_zero inst%0d: got %h want 4123", i, obs_rom[i]);
      end
    end
    wr_reg(16'h2000, 8'h03);
    drive(16'h4123, 8'h00, 1'b0, 1'b1, 1'b0);
    want = '{32'h4123, 32'hC123, 32'hC123};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rom[i] !== want[i] || obs_rd[i] !== exp_rd[i]) begin
        n_fail++;
        $display("FAIL bank1_wrap inst%0d: addr=%h rdata=%02h want %h/%02h", i, obs_rom[i], obs_rd[i], want[i], exp_rd[i]);
      end
    end
    wr_reg(16'h2000, 8'h01);
  endtask

  task automatic test_ram_hold();
    int cnt [3];
    for (int pass = 0; pass < 2; pass++) begin
      wr_reg(16'h0000, (pass == 0) ? 8'h0A : 8'h00);
      cnt = '{0, 0, 0};
      for (int k = 0; k < 4; k++) begin
        drive(16'hA010, 8'h5C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
          if (obs_we[i]) cnt[i]++;
          n_checks++;
          if (obs_ram[i] !== 32'h0010) begin
            n_fail++;
            $display("FAIL ram_addr inst%0d: got %h want 0010", i, obs_ram[i]);
          end
        end
      end
      drive(16'hA010, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (cnt[i] !== ((pass == 0) ? 1 : 0)) begin
          n_fail++;
          $display("FAIL ram_we_count pass%0d inst%0d: got %0d want %0d", pass, i, cnt[i], (pass == 0) ? 1 : 0);
        end
        n_checks++;
        if (obs_rd[i] !== ((pass == 0) ? 8'h5C : 8'hFF) || obs_rv[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL ram_read pass%0d inst%0d: got %02h want %02h", pass, i, obs_rd[i], (pass == 0) ? 8'h5C : 8'hFF);
        end
      end
    end
  endtask

  task automatic test_mode();
    wr_reg(16'h2000, 8'h00);
    wr_reg(16'h6000, 8'h01);
    wr_reg(16'h4000, 8'h02);
    drive(16'h0005, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_rom[2] !== 32'h100005 || obs_rom[0] !== 32'h0005) begin
      n_fail++;
      $display("FAIL mode_low: c=%h a=%h want 100005/0005", obs_rom[2], obs_rom[0]);
    end
    drive(16'h4005, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_rom[2] !== 32'h104005 || obs_rom[1] !== 32'h4005) begin
      n_fail++;
      $display("FAIL mode_high: c=%h b=%h want 104005/4005", obs_rom[2], obs_rom[1]);
    end
    drive(16'hA001, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_ram[2] !== 32'h4001 || obs_ram[0] !== 32'h0001) begin
      n_fail++;
      $display("FAIL mode_ram: c=%h a=%h want 4001/0001", obs_ram[2], obs_ram[0]);
    end
    wr_reg(16'h6000, 8'h00);
    wr_reg(16'h4000, 8'h00);
  endtask

  task automatic test_same_cycle();
    drive(16'h4000, 8'h01, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rom[i] !== 32'h4000 || obs_rd[i] !== rom_byte(32'h4000)) begin
        n_fail++;
        $display("FAIL same_cycle_old inst%0d: addr=%h rdata=%02h want 4000/%02h", i, obs_rom[i], obs_rd[i], rom_byte(32'h4000));
      end
    end
    drive(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_rom[2] !== 32'h84000 || obs_rd[2] !== exp_rd[2]) begin
      n_fail++;
      $display("FAIL same_cycle_new: addr=%h rdata=%02h want 84000/%02h", obs_rom[2], obs_rd[2], exp_rd[2]);
    end
    wr_reg(16'h2000, 8'h05);
    drive(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_rom[2] !== 32'h94000 || obs_rom[1] !== 32'h4000 || obs_rom[0] !== 32'h4000) begin
      n_fail++;
      $display("FAIL bank5: c=%h b=%h a=%h want 94000/4000/4000", obs_rom[2], obs_rom[1], obs_rom[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    wr_reg(16'h6000, 8'h01);
    wr_reg(16'h0000, 8'h0A);
    drive(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rv[i] !== 1'b0 || obs_rd[i] !== 8'hFF) begin
        n_fail++;
        $display("FAIL rst_mid_read inst%0d: rvalid=%0b rdata=%02h want 0/FF", i, obs_rv[i], obs_rd[i]);
      end
    end
    drive(16'h4000, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_rom[i] !== 32'h4000 || obs_en[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_regs inst%0d: addr=%h ram_en=%0b want 4000/0", i, obs_rom[i], obs_en[i]);
      end
    end
    drive(16'h0123, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_rom[2] !== 32'h0123) begin
      n_fail++;
      $display("FAIL rst_mode: got %h want 0123", obs_rom[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [6];
    addrs = '{16'h4001, 16'h0002, 16'hA003, 16'h8004, 16'h7FFF, 16'hE005};
    wr_reg(16'h0000, 8'h0A);
    for (int k = 0; k < 6; k++) begin
      drive(addrs[k], 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_rv[i] !== 1'b1 || obs_rd[i] !== exp_rd[i]) begin
          n_fail++;
          $display("FAIL b2b addr=%h inst%0d: rvalid=%0b rdata=%02h want 1/%02h", addrs[k], i, obs_rv[i], obs_rd[i], exp_rd[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    logic        wr, rd, r;
    a = 16'h0000; d = 8'h00;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = {3'($urandom_range(0, 7)), 13'($urandom)};
        if (a < 16'h2000 && $urandom_range(0, 1) == 0) d = {4'($urandom), 4'hA};
        else if ($urandom_range(0, 7) == 0)            d = 8'h00;
        else                                           d = 8'($urandom);
      end
      wr = ($urandom_range(0, 9) < 4);
      rd = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 63) == 0);
      drive(a, d, wr, rd, r);
      for (int i = 0; i < 3; i++) begin
        if (a < 16'h8000) begin
          n_checks++;
          if (obs_rom[i] !== exp_rom[i]) begin
            n_fail++;
            $display("FAIL rnd_rom_addr n=%0d inst%0d a=%h: got %h want %h", n, i, a, obs_rom[i], exp_rom[i]);
          end
        end
        if (in_ram(a)) begin
          n_checks++;
          if (obs_ram[i] !== exp_ram[i]) begin
            n_fail++;
            $display("FAIL rnd_ram_addr n=%0d inst%0d a=%h: got %h want %h", n, i, a, obs_ram[i], exp_ram[i]);
          end
        end
        n_checks++;
        if (obs_we[i] !== exp_we || obs_en[i] !== exp_en) begin
          n_fail++;
          $display("FAIL rnd_we_en n=%0d inst%0d: we=%0b en=%0b want %0b/%0b", n, i, obs_we[i], obs_en[i], exp_we, exp_en);
        end
        n_checks++;
        if (obs_rv[i] !== exp_rv || (exp_rv && obs_rd[i] !== exp_rd[i])) begin
          n_fail++;
          $display("FAIL rnd_read n=%0d inst%0d a=%h: rv=%0b rd=%02h want %0b/%02h", n, i, a, obs_rv[i], obs_rd[i], exp_rv, exp_rd[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 32768; j++) m_mem[i][j] = 8'h00;
    model_reset();
    cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0; rst = 1'b1;
    test_reset();
    test_basic_read();
    test_bank1();
    test_ram_hold();
    test_mode();
    test_same_cycle();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
